cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the RISC core.
- Owns the program counter. Steps each instruction through fetch, decode, execute, memory and writeback by driving one-hot stage enables to instruction memory, decoder, ALU, data memory and register-file write.
- Handles data-memory wait states, taken branches and halt requests.
- Replaces free-running testbench PC stepping with a real controller.

Parameters:
- PC_WIDTH, 32, width of the program counter.
- PC_STEP, 1, increment per sequential instruction (word addressing).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; leaves IDLE and begins execution.
- halt_req  input  1  request to stop after the current instruction retires.
- is_mem  input  1  from decoder; instruction uses data memory. Sampled in DECODE.
- reg_write  input  1  from decoder; instruction writes the register file. Sampled in DECODE.
- branch_taken  input  1  from ALU; redirect PC. Sampled in EXECUTE.
- branch_target  input  PC_WIDTH  redirect address. Sampled with branch_taken.
- mem_ready  input  1  data memory has completed the access.
- pc  output  PC_WIDTH  current instruction address.
- if_en  output  1  instruction memory read enable.
- id_en  output  1  decoder enable.
- ex_en  output  1  ALU enable.
- mem_en  output  1  data memory access enable.
- wb_en  output  1  register-file write enable.
- busy  output  1  high in any state except IDLE and HALTED.
- retired  output  1  one-cycle pulse when an instruction completes.
- instr_count  output  32  retired-instruction counter.

Behaviour:
- **Reset.** When reset=1 at a clock edge: next state IDLE, pc=RESET_PC, instr_count=0, latched flags and halt_pending cleared. Reset overrides all other inputs, including mid-instruction; a partially executed instruction does not retire.
- **States.** IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED.
- **Outputs are Moore decodes of state.**
  - if_en=FETCH; id_en=DECODE; ex_en=EXECUTE; mem_en=MEMORY.
  - wb_en=WRITEBACK and reg_write_q.
  - retired=WRITEBACK.
  - Every output is 0 in IDLE, HALTED and directly after reset.
- **Transitions.**
  - IDLE: go to FETCH when start=1, otherwise stay. halt_req is ignored in IDLE.
  - FETCH -> DECODE, unconditional.
  - DECODE -> EXECUTE. On this edge, latch is_mem_q and reg_write_q.
  - EXECUTE -> MEMORY if is_mem_q, else WRITEBACK. On this edge, latch br_q=branch_taken and tgt_q=branch_target.
  - MEMORY: stay while mem_ready=0; go to WRITEBACK on the edge where mem_ready=1. There is no timeout. mem_ready outside MEMORY is ignored.
  - WRITEBACK:
    - pc <= tgt_q if br_q, else pc+PC_STEP (wraps modulo 2^PC_WIDTH).
    - instr_count increments, saturating at 0xFFFFFFFF.
    - Next state HALTED if halt_pending or halt_req is 1, else FETCH.
  - HALTED: sticky; only reset exits. start is ignored.
- **Halt sampling.** halt_pending sets on any cycle with halt_req=1 while busy. It clears only on reset.
- **Latency.**
  - Non-memory instruction: 4 cycles, FETCH to WRITEBACK inclusive.
  - Memory instruction: 5 cycles plus N, where N is the number of cycles with mem_ready=0 in MEMORY.
  - pc is stable from FETCH through WRITEBACK and changes only on the WRITEBACK exit edge.
- **Invariants.**
  - At most one stage enable is high in any cycle.
  - A taken branch to the current pc is legal and loops.

Test Plan:
- Reset, start=1, is_mem=0, no branch, 3 instructions -> pc goes 0,1,2,3 at cycles 4/8/12 after FETCH entry; retired pulses every 4th cycle; instr_count=3.
- Memory instruction with mem_ready low for 3 MEMORY cycles -> mem_en high for 4 cycles; WRITEBACK 8 cycles after FETCH; pc=1.
- branch_taken=1, branch_target=0x40 in EXECUTE -> after WRITEBACK pc=0x40; next if_en cycle uses pc=0x40.
- halt_req pulsed for 1 cycle during DECODE of instruction at pc=5 -> instruction retires; pc=6; state HALTED; busy=0; start=1 has no effect.
- reset asserted during MEMORY stall at pc=7 with instr_count=7 -> next cycle IDLE, pc=0, instr_count=0, all enables 0, no retired pulse.
- RESET_PC=0xFFFFFFFF, one sequential instruction -> pc wraps to 0x00000000; wb_en follows reg_write (0 then 1 across two instructions).

Source files
------------

// File: rtl/cpu_sequencer.sv
`default_nettype none
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller.
// It owns the program counter and the retired-instruction counter.
module cpu_sequencer #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  PC_STEP  = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  input  logic                is_mem,
  input  logic                reg_write,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                mem_ready,
  output logic [PC_WIDTH-1:0] pc,
  output logic                if_en,
  output logic                id_en,
  output logic                ex_en,
  output logic                mem_en,
  output logic                wb_en,
  output logic                busy,
  output logic                retired,
  output logic [31:0]         instr_count
);

  localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                is_mem_q, is_mem_d;
  logic                reg_write_q, reg_write_d;
  logic                br_q, br_d;
  logic                halt_pending_q, halt_pending_d;
  logic                busy_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      tgt_q          <= '0;
      cnt_q          <= '0;
      is_mem_q       <= 1'b0;
      reg_write_q    <= 1'b0;
      br_q           <= 1'b0;
      halt_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      tgt_q          <= tgt_d;
      cnt_q          <= cnt_d;
      is_mem_q       <= is_mem_d;
      reg_write_q    <= reg_write_d;
      br_q           <= br_d;
      halt_pending_q <= halt_pending_d;
    end
  end

  always_comb begin
    busy_w         = (state_q != S_IDLE) && (state_q != S_HALTED);
    state_d        = state_q;
    pc_d           = pc_q;
    tgt_d          = tgt_q;
    cnt_d          = cnt_q;
    is_mem_d       = is_mem_q;
    reg_write_d    = reg_write_q;
    br_d           = br_q;
    // A halt request seen at any point of an instruction is honoured at its retirement.
    halt_pending_d = halt_pending_q | (halt_req & busy_w);

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d     = S_EXECUTE;
        is_mem_d    = is_mem;
        reg_write_d = reg_write;
      end
      S_EXECUTE: begin
        state_d = is_mem_q ? S_MEMORY : S_WRITEBACK;
        br_d    = branch_taken;
        tgt_d   = branch_target;
      end
      S_MEMORY: begin
        if (mem_ready) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d = br_q ? tgt_q : (pc_q + PC_INC);
        if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
        state_d = (halt_pending_q || halt_req) ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign busy        = busy_w;
  assign if_en       = (state_q == S_FETCH);
  assign id_en       = (state_q == S_DECODE);
  assign ex_en       = (state_q == S_EXECUTE);
  assign mem_en      = (state_q == S_MEMORY);
  assign wb_en       = (state_q == S_WRITEBACK) && reg_write_q;
  assign retired     = (state_q == S_WRITEBACK);

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// Directed scoreboard bench for cpu_sequencer; a second instance covers RESET_PC wrap.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, halt_req, is_mem, reg_write, branch_taken, mem_ready;
  logic [31:0] branch_target;
  logic [31:0] pc, instr_count, pc2, instr_count2;
  logic        if_en, id_en, ex_en, mem_en, wb_en, busy, retired;
  logic        if_en2, id_en2, ex_en2, mem_en2, wb_en2, busy2, retired2;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .is_mem(is_mem), .reg_write(reg_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_ready(mem_ready),
    .pc(pc), .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
    .wb_en(wb_en), .busy(busy), .retired(retired), .instr_count(instr_count)
  );

  cpu_sequencer #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .is_mem(is_mem), .reg_write(reg_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_ready(mem_ready),
    .pc(pc2), .if_en(if_en2), .id_en(id_en2), .ex_en(ex_en2), .mem_en(mem_en2),
    .wb_en(wb_en2), .busy(busy2), .retired(retired2), .instr_count(instr_count2)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        wb;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] m_pc, m2_pc, m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Retirement monitor: each retired pulse must match the oldest pushed expectation.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (retired === 1'b1) begin
      check("sb_retire_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_wb_en", wb_en, e.wb);
        check("sb_instr_count", instr_count, e.cnt);
      end
    end
  end

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pc  = 32'h0;
    m2_pc = 32'hFFFF_FFFF;
    m_cnt = 32'h0;
    check({tag, "_pc"}, pc, 64'h0);
    check({tag, "_pc2"}, pc2, 64'hFFFF_FFFF);
    check({tag, "_cnt"}, instr_count, 64'h0);
    check({tag, "_outs"}, {if_en, id_en, ex_en, mem_en, wb_en, busy, retired}, 64'h0);
  endtask

  // Drives one instruction starting in FETCH; leaves the DUT just past WRITEBACK.
  task automatic run_instr(input logic mem, input logic rw, input logic br,
                           input logic [31:0] tgt, input int stall,
                           input logic halt_pulse, input string tag);
    exp_t e;
    int   mem_cycles;
    e.pc = m_pc; e.wb = rw; e.cnt = m_cnt;
    sb_q.push_back(e);
    check({tag, "_fetch"}, {if_en, id_en, ex_en, mem_en, wb_en, busy, retired}, 64'b1000010);
    check({tag, "_fetch_pc"}, pc, m_pc);
    check({tag, "_fetch_pc2"}, pc2, m2_pc);
    is_mem    = mem;
    reg_write = rw;
    mem_ready = 1'b1;
    tick();
    check({tag, "_decode"}, {if_en, id_en, ex_en, mem_en, wb_en, retired}, 64'b010000);
    if (halt_pulse) halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    // Decoder inputs are scrambled after DECODE so only latched values may matter.
    is_mem    = ~mem;
    reg_write = ~rw;
    check({tag, "_execute"}, {if_en, id_en, ex_en, mem_en, wb_en, retired}, 64'b001000);
    branch_taken  = br;
    branch_target = tgt;
    tick();
    branch_taken  = ~br;
    branch_target = 32'hDEAD_BEEF;
    mem_cycles = 0;
    if (mem) begin
      mem_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        if (mem_en === 1'b1 && retired === 1'b0) mem_cycles++;
        tick();
      end
      mem_ready = 1'b1;
      if (mem_en === 1'b1 && retired === 1'b0) mem_cycles++;
      tick();
      check({tag, "_mem_cycles"}, mem_cycles, stall + 1);
    end
    check({tag, "_wb"}, {if_en, id_en, ex_en, mem_en, wb_en, busy, retired}, {5'b00000, 1'b1, 1'b1} | (64'(rw) << 2));
    check({tag, "_wb_pc"}, pc, m_pc);
    check({tag, "_d2_wb"}, {if_en2, id_en2, ex_en2, mem_en2, wb_en2, busy2, retired2}, {5'b00000, 1'b1, 1'b1} | (64'(rw) << 2));
    m_pc  = br ? tgt : m_pc + 32'd1;
    m2_pc = br ? tgt : m2_pc + 32'd1;
    m_cnt = m_cnt + 32'd1;
    is_mem = 1'b0; reg_write = 1'b0; branch_taken = 1'b0;
    tick();
    check({tag, "_next_pc"}, pc, m_pc);
    check({tag, "_next_pc2"}, pc2, m2_pc);
    check({tag, "_next_cnt"}, instr_count, m_cnt);
    check({tag, "_next_cnt2"}, instr_count2, m_cnt);
    check({tag, "_next_retired"}, retired, 64'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; is_mem = 1'b0; reg_write = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; mem_ready = 1'b0;
    m_pc = 32'h0; m2_pc = 32'hFFFF_FFFF; m_cnt = 32'h0;
    do_reset("reset0");

    // IDLE holds without start, and halt_req there must not stick.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    check("idle_hold", {if_en, busy, retired}, 64'h0);

    start = 1'b1;
    tick();
    start = 1'b0;

    // Sequential non-memory instructions; dut2 wraps 0xFFFFFFFF -> 0 on the first.
    run_instr(1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, "seq0");
    run_instr(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0, "seq1");
    run_instr(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0, "seq2");
    run_instr(1'b1, 1'b1, 1'b0, 32'h0, 3, 1'b0, "mem3");
    run_instr(1'b0, 1'b0, 1'b1, 32'h40, 0, 1'b0, "br4");
    run_instr(1'b1, 1'b0, 1'b1, 32'h40, 0, 1'b0, "selfloop");
    run_instr(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0, "after_loop");

    // Reset in the middle of a memory stall: no retirement, everything cleared.
    is_mem = 1'b1;
    tick();
    tick();
    is_mem = 1'b0;
    tick();
    mem_ready = 1'b0;
    tick();
    check("abort_in_mem", {mem_en, busy}, 64'b11);
    do_reset("reset_mid");
    mem_ready = 1'b1;
    tick();
    tick();
    check("abort_no_retire", {retired, busy, if_en}, 64'h0);

    // Halt pulsed during DECODE of the instruction at pc 5.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) run_instr(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0, "pre_halt");
    run_instr(1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b1, "halt5");
    check("halted_outs", {if_en, id_en, ex_en, mem_en, wb_en, busy, retired}, 64'h0);
    check("halted_pc", pc, 64'h6);
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    check("halted_sticky", {if_en, busy, retired}, 64'h0);
    check("halted_sticky_pc", pc, 64'h6);
    check("halted_cnt", instr_count, 64'h6);
    check("sb_drained", sb_q.size(), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
